// File: rtl/mem_bus_rr_arbiter_if.sv
// mem_bus_rr_arbiter_if
//  Bundles the two requester descriptor/handshake groups and the shared
//  memory bus beat outputs of mem_bus_rr_arbiter.
//  master : requester / traffic-agent side (drives req/wr/addr/len)
//  slave  : arbiter side (drives gnt/done and the bus beat signals)
//  Signals
//   reqN/wrN/addrN/lenN : burst descriptor of requester N (len = beats-1)
//   gntN/doneN          : first-beat / last-beat pulses for requester N
//   bus_en/bus_wr/bus_addr : beat valid, direction, address
//   busy                : arbiter is in a burst or the post-burst gap
interface mem_bus_rr_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 3
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [LEN_W-1:0]  len0;
    logic              gnt0;
    logic              done0;

    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [LEN_W-1:0]  len1;
    logic              gnt1;
    logic              done1;

    logic              bus_en;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic              busy;

    modport master (
        output req0, wr0, addr0, len0,
        output req1, wr1, addr1, len1,
        input  gnt0, done0, gnt1, done1,
        input  bus_en, bus_wr, bus_addr, busy
    );

    modport slave (
        input  req0, wr0, addr0, len0,
        input  req1, wr1, addr1, len1,
        output gnt0, done0, gnt1, done1,
        output bus_en, bus_wr, bus_addr, busy
    );
endinterface

// File: rtl/mem_bus_rr_arbiter.sv
// mem_bus_rr_arbiter
//  Two-requester round-robin arbiter/sequencer for the shared memory bus.
//  A granted burst descriptor (base addr, wr, len) is latched and played
//  out one beat per clock, followed by one idle gap cycle.
//  Ports
//   clk : system clock, posedge
//   rst : synchronous reset, active-high
//   bus : mem_bus_rr_arbiter_if.slave (requests in, grants and bus beats out)
//  Every output is a flop; the comb logic computes the value the outputs
//  must show in the cycle after the coming edge.
module mem_bus_rr_arbiter #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t            state_q, state_nxt;

    // rr pointer: requester favoured when both request (0 after reset)
    logic              ptr_q, ptr_nxt;
    logic              owner_q, owner_nxt;
    logic              wr_q, wr_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [LEN_W-1:0]  beat_q, beat_nxt;

    logic              grant;
    logic              win;
    logic              last_nxt;

    logic              en_d, wr_d, gnt0_d, gnt1_d, done0_d, done1_d, busy_d;
    logic [ADDR_W-1:0] addr_d;

    logic              en_q, bwr_q, gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic [ADDR_W-1:0] addr_q;

    // Requests are only looked at in IDLE; a sole requester always wins,
    // a tie goes to the pointer.
    assign grant = (state_q == IDLE) && (bus.req0 || bus.req1);
    assign win   = bus.req1 && (!bus.req0 || ptr_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (grant) state_nxt = BURST;
            BURST:   if (beat_q == len_q) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor latch, beat counter and rr pointer
    always_comb begin
        ptr_nxt   = ptr_q;
        owner_nxt = owner_q;
        wr_nxt    = wr_q;
        base_nxt  = base_q;
        len_nxt   = len_q;
        beat_nxt  = beat_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_nxt = win;
                    ptr_nxt   = ~win;
                    wr_nxt    = win ? bus.wr1   : bus.wr0;
                    base_nxt  = win ? bus.addr1 : bus.addr0;
                    len_nxt   = win ? bus.len1  : bus.len0;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                // beat never exceeds len, so the counter cannot wrap
                if (beat_q != len_q) beat_nxt = beat_q + LEN_W'(1);
            end
            default: ;
        endcase
    end

    // Output logic: values shown during the cycle after the coming edge
    always_comb begin
        en_d     = (state_nxt == BURST);
        last_nxt = (beat_nxt == len_nxt);
        wr_d     = en_d && wr_nxt;
        // address wraps naturally at ADDR_W bits
        addr_d   = en_d ? (base_nxt + ADDR_W'(beat_nxt)) : '0;
        gnt0_d   = grant && !win;
        gnt1_d   = grant && win;
        done0_d  = en_d && last_nxt && !owner_nxt;
        done1_d  = en_d && last_nxt && owner_nxt;
        busy_d   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            en_q    <= 1'b0;
            bwr_q   <= 1'b0;
            addr_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_nxt;
            owner_q <= owner_nxt;
            wr_q    <= wr_nxt;
            base_q  <= base_nxt;
            len_q   <= len_nxt;
            beat_q  <= beat_nxt;
            en_q    <= en_d;
            bwr_q   <= wr_d;
            addr_q  <= addr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.bus_en   = en_q;
    assign bus.bus_wr   = bwr_q;
    assign bus.bus_addr = addr_q;
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_rr_arbiter.sv
// tb_mem_bus_rr_arbiter
//  Directed bench for mem_bus_rr_arbiter. Each check compares the packed
//  output vector {busy,gnt0,done0,gnt1,done1,bus_en,bus_wr,bus_addr}
//  against a hand-computed value, sampled 1 time unit after posedge.
module tb_mem_bus_rr_arbiter;

    localparam int ADDR_W = 6;
    localparam int LEN_W  = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_bus_rr_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus_if ();

    mem_bus_rr_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic busy, input logic g0, input logic d0,
                                       input logic g1, input logic d1, input logic en,
                                       input logic wr, input logic [5:0] addr);
        return {busy, g0, d0, g1, d1, en, wr, addr};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = pk(bus_if.busy, bus_if.gnt0, bus_if.done0, bus_if.gnt1, bus_if.done1,
                 bus_if.bus_en, bus_if.bus_wr, bus_if.bus_addr);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %013b expected %013b", tag, obs, exp);
        end
    endtask

    localparam logic [12:0] ZERO = 13'b0;
    localparam logic [12:0] GAPV = 13'b1_0000_00_000000;

    initial begin
        rst = 1'b1;
        bus_if.req0 = 0; bus_if.wr0 = 0; bus_if.addr0 = '0; bus_if.len0 = '0;
        bus_if.req1 = 0; bus_if.wr1 = 0; bus_if.addr1 = '0; bus_if.len1 = '0;
        cyc(); cyc();
        chk("reset", ZERO);
        rst = 1'b0;
        cyc();
        chk("idle_no_req", ZERO);

        // 1: single write burst of two beats
        bus_if.req0 = 1; bus_if.addr0 = 6'h0C; bus_if.wr0 = 1; bus_if.len0 = 3'd1;
        cyc(); chk("t1_beat0", pk(1,1,0,0,0,1,1,6'h0C));
        bus_if.req0 = 0;
        cyc(); chk("t1_beat1", pk(1,0,1,0,0,1,1,6'h0D));
        cyc(); chk("t1_gap", GAPV);
        cyc(); chk("t1_idle", ZERO);

        // 2: simultaneous single-beat requests after reset, req0 first
        rst = 1; cyc(); rst = 0;
        bus_if.req0 = 1; bus_if.addr0 = 6'h01; bus_if.wr0 = 0; bus_if.len0 = 3'd0;
        bus_if.req1 = 1; bus_if.addr1 = 6'h20; bus_if.wr1 = 1; bus_if.len1 = 3'd0;
        cyc(); chk("t2_gnt0", pk(1,1,1,0,0,1,0,6'h01));
        bus_if.req0 = 0;
        cyc(); chk("t2_gap0", GAPV);
        cyc(); chk("t2_idle0", ZERO);
        // grant to req1 lands len+3 = 3 cycles after gnt0
        cyc(); chk("t2_gnt1", pk(1,0,0,1,1,1,1,6'h20));
        bus_if.req1 = 0;
        cyc(); chk("t2_gap1", GAPV);
        cyc(); chk("t2_idle1", ZERO);

        // 3: read burst wrapping the address space
        bus_if.req1 = 1; bus_if.addr1 = 6'h3E; bus_if.wr1 = 0; bus_if.len1 = 3'd3;
        cyc(); chk("t3_b0", pk(1,0,0,1,0,1,0,6'h3E));
        bus_if.req1 = 0;
        cyc(); chk("t3_b1", pk(1,0,0,0,0,1,0,6'h3F));
        cyc(); chk("t3_b2_wrap", pk(1,0,0,0,0,1,0,6'h00));
        cyc(); chk("t3_b3_done", pk(1,0,0,0,1,1,0,6'h01));
        cyc(); chk("t3_gap", GAPV);
        cyc(); chk("t3_idle", ZERO);

        // 4: reset during beat 2, held request restarts from base
        bus_if.req0 = 1; bus_if.addr0 = 6'h10; bus_if.wr0 = 1; bus_if.len0 = 3'd3;
        cyc(); chk("t4_b0", pk(1,1,0,0,0,1,1,6'h10));
        cyc(); chk("t4_b1", pk(1,0,0,0,0,1,1,6'h11));
        cyc(); chk("t4_b2", pk(1,0,0,0,0,1,1,6'h12));
        rst = 1;
        cyc(); chk("t4_rst_abort", ZERO);
        rst = 0;
        cyc(); chk("t4_restart", pk(1,1,0,0,0,1,1,6'h10));
        bus_if.req0 = 0;
        cyc(); chk("t4_r1", pk(1,0,0,0,0,1,1,6'h11));
        cyc(); chk("t4_r2", pk(1,0,0,0,0,1,1,6'h12));
        cyc(); chk("t4_r3_done", pk(1,0,1,0,0,1,1,6'h13));
        cyc(); chk("t4_gap", GAPV);
        cyc(); chk("t4_idle", ZERO);

        // 5: both held high, single-beat bursts alternate 0,1,0,1
        rst = 1; cyc(); rst = 0;
        bus_if.req0 = 1; bus_if.addr0 = 6'h05; bus_if.wr0 = 1; bus_if.len0 = 3'd0;
        bus_if.req1 = 1; bus_if.addr1 = 6'h2A; bus_if.wr1 = 0; bus_if.len1 = 3'd0;
        for (int i = 0; i < 12; i++) begin
            logic [12:0] e;
            cyc();
            if (i % 3 == 0) begin
                if ((i / 3) % 2 == 0) e = pk(1,1,1,0,0,1,1,6'h05);
                else                  e = pk(1,0,0,1,1,1,0,6'h2A);
            end else if (i % 3 == 1) e = GAPV;
            else                     e = ZERO;
            chk($sformatf("t5_c%0d", i), e);
        end
        bus_if.req0 = 0; bus_if.req1 = 0;
        cyc(); chk("t5_quiet", ZERO);

        // 6: descriptor inputs change mid-burst
        bus_if.req0 = 1; bus_if.addr0 = 6'h08; bus_if.wr0 = 1; bus_if.len0 = 3'd2;
        cyc(); chk("t6_b0", pk(1,1,0,0,0,1,1,6'h08));
        bus_if.req0 = 0; bus_if.addr0 = 6'h30; bus_if.wr0 = 0; bus_if.len0 = 3'd0;
        bus_if.addr1 = 6'h11; bus_if.len1 = 3'd5;
        cyc(); chk("t6_b1", pk(1,0,0,0,0,1,1,6'h09));
        cyc(); chk("t6_b2_done", pk(1,0,1,0,0,1,1,6'h0A));
        cyc(); chk("t6_gap", GAPV);
        cyc(); chk("t6_idle", ZERO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
